// File: rtl/argmax_pkg.sv
// rtl/argmax_pkg.sv - shared types and constants for the row-wise argmax engine
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } argmax_state_t;

  localparam logic CMP_UNSIGNED = 1'b0;
  localparam logic CMP_SIGNED   = 1'b1;

  localparam int GCN_DATA_WIDTH = 16;
  typedef logic [GCN_DATA_WIDTH-1:0] gcn_data_t;

endpackage

// File: rtl/argmax_row_cmp.sv
// rtl/argmax_row_cmp.sv - combinational argmax over one row, signed or unsigned compare
module argmax_row_cmp
  import argmax_pkg::*;
#(
  parameter int COLS       = 3,
  parameter int DATA_WIDTH = GCN_DATA_WIDTH,
  parameter int IDX_WIDTH  = $clog2(COLS)
) (
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] row [0:COLS-1],
  output logic [IDX_WIDTH-1:0]  max_idx,
  output logic [DATA_WIDTH-1:0] max_val
);

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    max_idx = '0;
    max_val = row[0];
    for (int i = 1; i < COLS; i++) begin
      if ((mode == CMP_SIGNED) ? ($signed(row[i]) > $signed(max_val))
                               : (row[i] > max_val)) begin
        max_val = row[i];
        max_idx = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/argmax_rows_stream.sv
// rtl/argmax_rows_stream.sv - streaming per-row argmax with a frame result buffer and done flag
module argmax_rows_stream
  import argmax_pkg::*;
#(
  parameter int ROWS       = 6,
  parameter int COLS       = 3,
  parameter int DATA_WIDTH = GCN_DATA_WIDTH,
  parameter int IDX_WIDTH  = $clog2(COLS),
  parameter int ROW_WIDTH  = $clog2(ROWS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_row      [0:COLS-1],
  output logic [IDX_WIDTH-1:0]  max_idx_out [0:ROWS-1],
  output logic [DATA_WIDTH-1:0] max_val_out [0:ROWS-1],
  output logic                  busy,
  output logic                  done
);

  argmax_state_t         state_q, state_d;
  logic                  mode_q;
  logic [ROW_WIDTH-1:0]  row_cnt_q;
  logic [DATA_WIDTH-1:0] stage_row_q [0:COLS-1];
  logic [ROW_WIDTH-1:0]  stage_sel_q;
  logic                  stage_valid_q;
  logic [IDX_WIDTH-1:0]  cmp_idx;
  logic [DATA_WIDTH-1:0] cmp_val;

  logic accept, last_accept, frame_start;

  assign accept      = in_valid && (state_q == RUN);
  assign last_accept = accept && (row_cnt_q == ROW_WIDTH'(ROWS - 1));
  assign frame_start = start && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_accept) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Only the final row can still be staged here.
        if (stage_valid_q) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  argmax_row_cmp #(
    .COLS       (COLS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_row_cmp (
    .mode    (mode_q),
    .row     (stage_row_q),
    .max_idx (cmp_idx),
    .max_val (cmp_val)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q        <= CMP_UNSIGNED;
      row_cnt_q     <= '0;
      stage_sel_q   <= '0;
      stage_valid_q <= 1'b0;
      for (int c = 0; c < COLS; c++) stage_row_q[c] <= '0;
      for (int r = 0; r < ROWS; r++) begin
        max_idx_out[r] <= '0;
        max_val_out[r] <= '0;
      end
    end else if (frame_start) begin
      mode_q        <= signed_mode;
      row_cnt_q     <= '0;
      stage_valid_q <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        max_idx_out[r] <= '0;
        max_val_out[r] <= '0;
      end
    end else begin
      if (stage_valid_q) begin
        max_idx_out[stage_sel_q] <= cmp_idx;
        max_val_out[stage_sel_q] <= cmp_val;
      end
      stage_valid_q <= accept;
      if (accept) begin
        stage_row_q <= in_row;
        stage_sel_q <= row_cnt_q;
        row_cnt_q   <= ROW_WIDTH'(row_cnt_q + 1'b1);
      end
    end
  end

endmodule

// File: doc/argmax_rows_stream.md
# argmax_rows_stream

Streaming, parametrised row-wise argmax engine for the GCN classification output stage. It accepts one row of the ADJ×FM×WM product per handshake and finds the column index and value of the row maximum, with selectable signed or unsigned compare. Per-row results are held in a result buffer, and a done flag is raised once a full frame of `ROWS` rows has been processed. It sits between the combination (matrix-product) stage and the result readout.

## Interface
- `ROWS`, 6, rows per frame
- `COLS`, 3, columns per row (≥2)
- `DATA_WIDTH`, 16, bits per matrix element
- `IDX_WIDTH`, `$clog2(COLS)`, width of the column index
- `ROW_WIDTH`, `$clog2(ROWS)`, width of the row counter

Ports:
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse that begins a frame; latches `signed_mode`
- `signed_mode`  in  1  1 = two's-complement compare, 0 = unsigned
- `in_valid`  in  1  `in_row` holds a valid row
- `in_ready`  out  1  block accepts a row this cycle
- `in_row`  in  `DATA_WIDTH` × [0:COLS-1]  one matrix row
- `max_idx_out`  out  `IDX_WIDTH` × [0:ROWS-1]  argmax column index per row
- `max_val_out`  out  `DATA_WIDTH` × [0:ROWS-1]  maximum value per row
- `busy`  out  1  frame in progress (RUN or DRAIN)
- `done`  out  1  level signal: all `ROWS` results are valid

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- IDLE/DONE + `start` → RUN. On that edge:
  - latch `signed_mode`
  - clear the row counter, all `max_idx_out`, all `max_val_out`, the stage valid bit, and `done`.
- In RUN, `start` is ignored and `in_ready` = 1.
- A row is accepted when `in_valid && in_ready`.
  - The accepted row and the current row counter are loaded into the stage register, and the stage valid bit is set.
  - The counter increments.
  - On the `ROWS`-th accept, the FSM goes RUN → DRAIN and `in_ready` drops from the next cycle.
- Stage 2 (sub-module, combinational): scan the stage row for the maximum. A column replaces the current best only if strictly greater, so ties resolve to the lowest index. Signedness follows the latched mode.
  - On the next edge, write the index and value to entry [stage row] and clear the stage valid bit.
- DRAIN → DONE on the edge that writes the last result. `done` = 1 in DONE; results hold until the next `start`.
- `in_ready` = 0 in IDLE, DRAIN and DONE. Rows presented there are not consumed.
- `busy` = 1 in RUN and DRAIN.
- Gaps in `in_valid` are legal; the row counter only advances on accepts.
- `IDX_WIDTH` is zero-extended from the loop index; `max_val_out` keeps the raw bits of the input.

## Timing
- Reset (asynchronous, `reset_n` = 0): `in_ready` = 0, `busy` = 0, `done` = 0, all `max_idx_out` = 0, all `max_val_out` = 0, FSM = IDLE, stage valid bit = 0, row counter = 0.
- Reset mid-frame aborts the frame: a partial frame is discarded and never flagged done.
- Latency:
  - Accept at edge t → result entry written at edge t+1.
  - Last accept at edge t → `done` high after edge t+1.
- Maximum throughput is one row per cycle with back-to-back accepts; no bubbles are required.
- `start` and `in_valid` in the same cycle as an IDLE → RUN transition: the row is not accepted (`in_ready` is still 0).
- `start` in DONE: `done` falls after that edge.

## Structure
- Shared package `argmax_pkg`:
  - `argmax_state_t` enum (IDLE/RUN/DRAIN/DONE)
  - compare-mode constants
  - `gcn_data_t` typedef for element width defaults
- Sub-module `argmax_row_cmp`: parametrised combinational reduction over `COLS` elements with a signed/unsigned select. It outputs the index and value. It is reused by future top-k variants.

## Test plan
- Unsigned frame, rows {5,9,2},{1,1,8},{7,3,7},{0,0,0},{65535,2,3},{4,12,11}, back-to-back → idx {1,2,0,0,0,1}, vals {9,8,7,0,65535,12}; `done` one cycle after the 6th accept.
- Signed mode, row {16'hFFFF,16'h0001,16'h8000} → idx 1, val 16'h0001. The same row in unsigned mode → idx 0, val 16'hFFFF.
- Ties: row {7,7,7} → idx 0; row {3,9,9} → idx 1.
- Backpressure: `in_valid` toggled 1-0-1 → exactly 6 accepts; `in_ready` = 0 after the 6th; extra valid rows are not consumed; results are correct.
- Reset: assert `reset_n` = 0 after 3 accepts → all outputs 0, IDLE; a new `start` then 6 rows gives a correct frame.
- `start` during RUN → ignored, counter unchanged. `start` in DONE → `done` falls next cycle and results clear to 0.
